// File: rtl/div_seq_if.sv
// div_seq_if: operand/result bundle for the sequential divider.
//   master : drives a, b, start; observes q, rem, busy, done, dbz
//   slave  : the divider side of the same signals
// a, b     : unsigned dividend / divisor (W bits)
// start    : operation request, sampled on the rising clock edge
// q, rem   : unsigned quotient / remainder (W bits)
// busy     : a division is in progress
// done     : q, rem and dbz hold a valid result (level)
// dbz      : divide-by-zero flag, meaningful while done is high
interface div_seq_if #(parameter int W = 8);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         start;
  logic [W-1:0] q;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         dbz;

  modport master (output a, b, start, input q, rem, busy, done, dbz);
  modport slave  (input a, b, start, output q, rem, busy, done, dbz);
endinterface

// File: rtl/div_seq.sv
// div_seq: W-bit unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset, clears every register
//   bus   : div_seq_if.slave carrying a, b, start, q, rem, busy, done, dbz
// A start seen in IDLE or DONE latches the operands. A nonzero divisor
// takes W CALC cycles (busy high) before DONE; a zero divisor spends one
// quiet CALC cycle (busy low) and then reports q = all ones, rem = a, dbz = 1.
// Starts arriving during CALC are ignored.
module div_seq #(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  div_seq_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    p_shift;
  logic          q_bit;
  logic [W-1:0]  p_step;
  logic [W-1:0]  dvd_step;

  // One restoring step. p_shift is the (W+1)-bit partial remainder; its top
  // bit set means it already exceeds any W-bit divisor. The subtraction is
  // only kept when it fits, so the low W bits of the difference are exact.
  always_comb begin
    p_shift  = {p_q, dvd_q[W-1]};
    q_bit    = p_shift[W] | (p_shift[W-1:0] >= dvs_q);
    p_step   = q_bit ? (p_shift[W-1:0] - dvs_q) : p_shift[W-1:0];
    dvd_step = {dvd_q[W-2:0], q_bit};
  end

  // Next-state logic. The dividend register doubles as the quotient: each
  // step shifts the dividend MSB out and the new quotient bit in.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = CALC;
          dvd_d   = bus.a;
          dvs_d   = bus.b;
          p_d     = '0;
          cnt_d   = CW'(W - 1);
          q_d     = '0;
          rem_d   = '0;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          busy_d  = (bus.b != '0);
        end
      end
      CALC: begin
        if (dvs_q == '0) begin
          state_d = DONE;
          q_d     = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          p_d   = p_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            q_d     = dvd_step;
            rem_d   = p_step;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.rem  = rem_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed scoreboard bench for div_seq (W = 8).
// Stimulus pushes the hand-computed result and its expected latency; a
// monitor pops one entry each time done rises and compares it.
module tb_div_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         dbz;
    int           e0;
    int           lat;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   check_count;
  int   pass_count;
  exp_t sb[$];

  div_seq_if #(.W(W)) bus ();

  div_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the last edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      pass_count++;
  endtask

  // Issue a one-cycle start at the next falling edge, then scramble the
  // operands so a result that depends on them after the accept edge shows.
  task automatic applyStimulus(input string name, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [W-1:0] qv,
                               input logic [W-1:0] rv, input logic dv,
                               input int lat);
    exp_t e;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    e.q = qv; e.rem = rv; e.dbz = dv; e.e0 = cyc + 1; e.lat = lat; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      check_count++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare every new result against the oldest expectation.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_done: got q=%0d rem=%0d, expected no result",
                   bus.q, bus.rem);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, ".q"},       32'(bus.q),    32'(e.q));
          checkOutput({e.name, ".rem"},     32'(bus.rem),  32'(e.rem));
          checkOutput({e.name, ".dbz"},     32'(bus.dbz),  32'(e.dbz));
          checkOutput({e.name, ".busy"},    32'(bus.busy), 32'd0);
          checkOutput({e.name, ".latency"}, 32'(cyc - e.e0), 32'(e.lat));
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    exp_t e;
    check_count = 0;
    pass_count  = 0;
    rst_n     = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.start = 1'b0;

    #12;
    checkOutput("reset.q",    32'(bus.q),    32'd0);
    checkOutput("reset.rem",  32'(bus.rem),  32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.dbz",  32'(bus.dbz),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] 100/7 with hold");
    applyStimulus("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    checkOutput("d100_7.busy_calc", 32'(bus.busy), 32'd1);
    waitDrain(20);
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold.done", 32'(bus.done), 32'd1);
      checkOutput("hold.q",    32'(bus.q),    32'd14);
      checkOutput("hold.rem",  32'(bus.rem),  32'd2);
    end

    $display("[TB] boundary operands");
    applyStimulus("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    waitDrain(20);
    applyStimulus("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    waitDrain(20);
    applyStimulus("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);
    waitDrain(20);

    $display("[TB] divide by zero");
    applyStimulus("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1);
    checkOutput("d200_0.busy", 32'(bus.busy), 32'd0);
    waitDrain(20);

    $display("[TB] start re-pulsed during CALC");
    applyStimulus("repulse", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    @(negedge clk);
    bus.a     = 8'd9;
    bus.b     = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDrain(20);

    $display("[TB] reset mid-CALC");
    applyStimulus("aborted", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.done", 32'(bus.done), 32'd0);
    checkOutput("abort.q",    32'(bus.q),    32'd0);
    checkOutput("abort.rem",  32'(bus.rem),  32'd0);
    checkOutput("abort.dbz",  32'(bus.dbz),  32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("d81_9", 8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 8);
    waitDrain(20);

    $display("[TB] start held high, back-to-back");
    @(negedge clk);
    bus.a     = 8'd50;
    bus.b     = 8'd6;
    bus.start = 1'b1;
    e.q = 8'd8; e.rem = 8'd2; e.dbz = 1'b0; e.e0 = cyc + 1; e.lat = 8; e.name = "b2b_50_6";
    sb.push_back(e);
    @(negedge clk);
    bus.a = 8'd13;
    bus.b = 8'd13;
    e.q = 8'd1; e.rem = 8'd0; e.dbz = 1'b0; e.e0 = e.e0 + 9; e.lat = 8; e.name = "b2b_13_13";
    sb.push_back(e);
    repeat (8) @(negedge clk);
    checkOutput("b2b.first_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    checkOutput("b2b.done_one_cycle", 32'(bus.done), 32'd0);
    checkOutput("b2b.busy_restart",   32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    waitDrain(20);
    repeat (2) @(negedge clk);
    checkOutput("b2b.final_done", 32'(bus.done), 32'd1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
